// File: rtl/proj_fm_ram_arbiter.sv
// proj_fm_ram_arbiter
// Front-end for the single-port feature-map RAM. After reset it sweeps
// every entry to zero (INIT). It then shares the RAM between the loader
// (port A, read/write) and the MinHash engine (port B, read-only) using
// round-robin arbitration (RUN).
//
// Handshake: a request transfers in the cycle where in_x_valid && out_x_ready.
// Ready is combinational from valid and is never asserted without valid.
// An unaccepted request may change or drop. Every accepted read gets exactly
// one out_x_rvalid pulse in the following cycle. Writes get no response.
//
// Ports
//   in_clk, in_rst_n           clock, synchronous active-low reset
//   in_a_*/out_a_*             loader request (valid/ready/we/addr/wdata) and read response
//   in_b_*/out_b_*             MinHash read request (valid/ready/addr) and read response
//   out_ram_*/in_ram_rdata     RAM drive; read data arrives the cycle after the read
//   out_init_done              high once the sweep has finished (RUN state)
module proj_fm_ram_arbiter #(
    parameter int ENTRIES   = 32,
    parameter int DATA_BITS = 8,
    localparam int ADDR_BITS = $clog2(ENTRIES)
) (
    input  logic                 in_clk,
    input  logic                 in_rst_n,
    input  logic                 in_a_valid,
    output logic                 out_a_ready,
    input  logic                 in_a_we,
    input  logic [ADDR_BITS-1:0] in_a_addr,
    input  logic [DATA_BITS-1:0] in_a_wdata,
    output logic                 out_a_rvalid,
    output logic [DATA_BITS-1:0] out_a_rdata,
    input  logic                 in_b_valid,
    output logic                 out_b_ready,
    input  logic [ADDR_BITS-1:0] in_b_addr,
    output logic                 out_b_rvalid,
    output logic [DATA_BITS-1:0] out_b_rdata,
    output logic [ADDR_BITS-1:0] out_ram_addr,
    output logic                 out_ram_we,
    output logic [DATA_BITS-1:0] out_ram_wdata,
    input  logic [DATA_BITS-1:0] in_ram_rdata,
    output logic                 out_init_done
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // One extra bit so the range check also works when ENTRIES is a power of two.
    localparam logic [ADDR_BITS:0]   ENTRIES_EXT = (ADDR_BITS + 1)'(ENTRIES);
    localparam logic [ADDR_BITS-1:0] LAST_ADDR   = ADDR_BITS'(ENTRIES - 1);

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] cnt_q, cnt_d;
    logic                 last_b_q, last_b_d;   // 1: most recent grant went to B
    logic                 rsp_a_q, rsp_b_q, rsp_in_range_q;
    logic                 grant_a, grant_b;
    logic                 a_in_range, b_in_range;

    assign a_in_range = ({1'b0, in_a_addr} < ENTRIES_EXT);
    assign b_in_range = ({1'b0, in_b_addr} < ENTRIES_EXT);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_b_d      = last_b_q;
        grant_a       = 1'b0;
        grant_b       = 1'b0;
        out_ram_addr  = '0;
        out_ram_we    = 1'b0;
        out_ram_wdata = '0;
        case (state_q)
            ST_INIT: begin
                out_ram_addr = cnt_q;
                out_ram_we   = 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                // On a tie A wins only if B was granted last.
                grant_a = in_a_valid && (!in_b_valid || last_b_q);
                grant_b = in_b_valid && !grant_a;
                if (grant_a) begin
                    out_ram_addr  = in_a_addr;
                    out_ram_we    = in_a_we && a_in_range;
                    out_ram_wdata = in_a_wdata;
                    last_b_d      = 1'b0;
                end else if (grant_b) begin
                    out_ram_addr = in_b_addr;
                    last_b_d     = 1'b1;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            state_q        <= ST_INIT;
            cnt_q          <= '0;
            last_b_q       <= 1'b1;
            rsp_a_q        <= 1'b0;
            rsp_b_q        <= 1'b0;
            rsp_in_range_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            last_b_q       <= last_b_d;
            rsp_a_q        <= grant_a && !in_a_we;
            rsp_b_q        <= grant_b;
            rsp_in_range_q <= grant_a ? a_in_range : b_in_range;
        end
    end

    assign out_a_ready   = grant_a;
    assign out_b_ready   = grant_b;
    assign out_a_rvalid  = rsp_a_q;
    assign out_b_rvalid  = rsp_b_q;
    // Out-of-range reads still answer, but with zero instead of RAM contents.
    assign out_a_rdata   = (rsp_a_q && rsp_in_range_q) ? in_ram_rdata : '0;
    assign out_b_rdata   = (rsp_b_q && rsp_in_range_q) ? in_ram_rdata : '0;
    assign out_init_done = (state_q == ST_RUN);

endmodule

// File: tb/tb_proj_fm_ram_arbiter.sv
// Bench for proj_fm_ram_arbiter: a 32-entry instance checked against a
// rule-level model every cycle, plus a 20-entry instance for out-of-range.
module tb_proj_fm_ram_arbiter;
    localparam int ENTRIES = 32;
    localparam int E20     = 20;
    localparam int DW      = 8;
    localparam int AW      = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0;
    logic          a_valid = 1'b0, a_we = 1'b0, b_valid = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_wdata = '0;

    logic          a_ready, a_rvalid, b_ready, b_rvalid, ram_we, init_done;
    logic [DW-1:0] a_rdata, b_rdata, ram_wdata, ram_rdata;
    logic [AW-1:0] ram_addr;

    logic          a_ready_20, a_rvalid_20, b_ready_20, b_rvalid_20, ram_we_20, init_done_20;
    logic [DW-1:0] a_rdata_20, b_rdata_20, ram_wdata_20, ram_rdata_20;
    logic [AW-1:0] ram_addr_20;

    proj_fm_ram_arbiter #(.ENTRIES(ENTRIES), .DATA_BITS(DW)) u_dut (
        .in_clk(clk), .in_rst_n(rst_n),
        .in_a_valid(a_valid), .out_a_ready(a_ready), .in_a_we(a_we),
        .in_a_addr(a_addr), .in_a_wdata(a_wdata),
        .out_a_rvalid(a_rvalid), .out_a_rdata(a_rdata),
        .in_b_valid(b_valid), .out_b_ready(b_ready), .in_b_addr(b_addr),
        .out_b_rvalid(b_rvalid), .out_b_rdata(b_rdata),
        .out_ram_addr(ram_addr), .out_ram_we(ram_we), .out_ram_wdata(ram_wdata),
        .in_ram_rdata(ram_rdata), .out_init_done(init_done)
    );

    proj_fm_ram_arbiter #(.ENTRIES(E20), .DATA_BITS(DW)) u_dut20 (
        .in_clk(clk), .in_rst_n(rst_n),
        .in_a_valid(a_valid), .out_a_ready(a_ready_20), .in_a_we(a_we),
        .in_a_addr(a_addr), .in_a_wdata(a_wdata),
        .out_a_rvalid(a_rvalid_20), .out_a_rdata(a_rdata_20),
        .in_b_valid(b_valid), .out_b_ready(b_ready_20), .in_b_addr(b_addr),
        .out_b_rvalid(b_rvalid_20), .out_b_rdata(b_rdata_20),
        .out_ram_addr(ram_addr_20), .out_ram_we(ram_we_20), .out_ram_wdata(ram_wdata_20),
        .in_ram_rdata(ram_rdata_20), .out_init_done(init_done_20)
    );

    // ---------------- RAM environments (registered read) ----------------
    logic          fill_ff = 1'b0;
    logic [DW-1:0] ram32 [ENTRIES];
    logic [DW-1:0] ram20 [E20];
    logic [DW-1:0] snap20 [E20];

    always @(posedge clk) begin
        if (fill_ff) begin
            for (int i = 0; i < ENTRIES; i++) ram32[i] <= 8'hFF;
        end else begin
            ram_rdata <= ram32[ram_addr];
            if (ram_we) ram32[ram_addr] <= ram_wdata;
        end
    end

    always @(posedge clk) begin
        if (int'(ram_addr_20) < E20) ram_rdata_20 <= ram20[ram_addr_20];
        else                         ram_rdata_20 <= 8'hA5;
        if (ram_we_20 && int'(ram_addr_20) < E20) ram20[ram_addr_20] <= ram_wdata_20;
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: sweep progress, RUN flag, who was served last,
    // expected memory contents and the response due next cycle.
    bit            m_known = 1'b0;
    bit            m_run = 1'b0;
    int            m_cnt = 0;
    bit            m_last_b = 1'b1;
    logic [DW-1:0] m_mem [ENTRIES];
    bit            exp_a_rv = 1'b0, exp_b_rv = 1'b0;
    logic [DW-1:0] exp_rdata = '0;

    // ---------------- driver: one cycle ----------------
    task automatic step(input bit rst, input bit av, input bit awe, input logic [AW-1:0] aaddr,
                        input logic [DW-1:0] awd, input bit bv, input logic [AW-1:0] baddr);
        bit ga = 1'b0;
        bit gb = 1'b0;
        @(negedge clk);
        rst_n = rst; a_valid = av; a_we = awe; a_addr = aaddr; a_wdata = awd;
        b_valid = bv; b_addr = baddr;
        #1;
        if (m_known) begin
            check("a_rvalid", a_rvalid, exp_a_rv);
            check("b_rvalid", b_rvalid, exp_b_rv);
            check("a_rdata", a_rdata, exp_a_rv ? exp_rdata : 8'h00);
            check("b_rdata", b_rdata, exp_b_rv ? exp_rdata : 8'h00);
            check("init_done", init_done, m_run);
            if (!m_run) begin
                check("init_addr", ram_addr, m_cnt);
                check("init_we", ram_we, 1);
                check("init_wdata", ram_wdata, 0);
                check("init_a_ready", a_ready, 0);
                check("init_b_ready", b_ready, 0);
            end else begin
                if (av && bv) begin
                    ga = m_last_b;
                    gb = !m_last_b;
                end else begin
                    ga = av;
                    gb = bv;
                end
                check("a_ready", a_ready, ga);
                check("b_ready", b_ready, gb);
                check("ram_addr", ram_addr, ga ? aaddr : (gb ? baddr : 5'd0));
                check("ram_we", ram_we, ga && awe);
                check("ram_wdata", ram_wdata, ga ? awd : 8'h00);
            end
        end
        exp_a_rv  = 1'b0;
        exp_b_rv  = 1'b0;
        exp_rdata = '0;
        if (!rst) begin
            m_known = 1'b1; m_run = 1'b0; m_cnt = 0; m_last_b = 1'b1;
        end else if (m_known) begin
            if (!m_run) begin
                m_mem[m_cnt] = '0;
                m_cnt++;
                if (m_cnt == ENTRIES) m_run = 1'b1;
            end else if (ga) begin
                m_last_b = 1'b0;
                if (awe) m_mem[aaddr] = awd;
                else begin exp_a_rv = 1'b1; exp_rdata = m_mem[aaddr]; end
            end else if (gb) begin
                m_last_b = 1'b1;
                exp_b_rv = 1'b1;
                exp_rdata = m_mem[baddr];
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, '0, '0, 0, '0);
    endtask

    task automatic random_steps(input int n, input bit rst);
        for (int i = 0; i < n; i++)
            step(rst, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)),
                 DW'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // Reset with the RAM pre-filled to 0xFF.
        fill_ff = 1'b1;
        step(0, 1, 0, 5'd1, 8'h11, 1, 5'd2);
        step(0, 1, 0, 5'd1, 8'h11, 1, 5'd2);
        step(0, 1, 0, 5'd1, 8'h11, 1, 5'd2);
        fill_ff = 1'b0;
        check("rst_a_ready", a_ready, 0);
        check("rst_b_rvalid", b_rvalid, 0);

        // Sweep: 32 cycles with random request noise; readys must stay low.
        check("sweep_first_addr_pending", init_done, 0);
        random_steps(ENTRIES, 1);

        // Contention right after the sweep: A,B,A,B,A,B.
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 0, AW'(i), 8'h00, 1, AW'(31 - i));
            check("cont_a_grant", a_ready, (i % 2) == 0);
            check("cont_b_grant", b_ready, (i % 2) == 1);
            if (i == 0) begin
                for (int k = 0; k < ENTRIES; k++) check("sweep_zero", ram32[k], 8'h00);
            end
        end

        // Idle in RUN.
        idle(100);

        // A writes 0x5A to 7, then B reads 7.
        step(1, 1, 1, 5'd7, 8'h5A, 0, '0);
        step(1, 0, 0, '0, '0, 1, 5'd7);
        step(1, 0, 0, '0, '0, 0, '0);
        check("wr_rd_b_rvalid", b_rvalid, 1);
        check("wr_rd_b_rdata", b_rdata, 8'h5A);
        check("wr_rd_a_rvalid", a_rvalid, 0);

        // Random traffic.
        random_steps(300, 1);
        idle(2);

        // Out of range on the 20-entry instance.
        for (int k = 0; k < E20; k++) snap20[k] = ram20[k];
        check("oor_init_done", init_done_20, 1);
        step(1, 1, 1, 5'd25, 8'h33, 0, '0);
        check("oor_wr_ready", a_ready_20, 1);
        check("oor_wr_we", ram_we_20, 0);
        step(1, 1, 0, 5'd25, 8'h00, 0, '0);
        check("oor_rd_ready", a_ready_20, 1);
        step(1, 0, 0, '0, '0, 0, '0);
        check("oor_rd_rvalid", a_rvalid_20, 1);
        check("oor_rd_rdata", a_rdata_20, 8'h00);
        for (int k = 0; k < E20; k++) check("oor_mem_kept", ram20[k], snap20[k]);

        // Reset one cycle after an accepted B read, then a full sweep.
        step(1, 0, 0, '0, '0, 1, 5'd3);
        step(0, 0, 0, '0, '0, 0, '0);
        step(0, 0, 0, '0, '0, 0, '0);
        check("rst_mid_b_rvalid", b_rvalid, 0);
        step(1, 0, 0, '0, '0, 0, '0);
        check("resweep_addr0", ram_addr, 0);
        random_steps(ENTRIES, 1);

        // Reset sampled in the same cycle a read is accepted: response dropped.
        step(0, 0, 0, '0, '0, 1, 5'd9);
        step(0, 0, 0, '0, '0, 0, '0);
        check("rst_same_b_rvalid", b_rvalid, 0);
        random_steps(ENTRIES + 1, 1);
        random_steps(100, 1);
        idle(2);

        for (int k = 0; k < ENTRIES; k++) check("final_mem", ram32[k], m_mem[k]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
